// File: rtl/ddr2_local_responder_pkg.sv
// ddr2_local_pkg: default widths and constants shared
// by the DDR2 local-interface responder files.
package ddr2_local_pkg;

   localparam int DEF_ADDR_WIDTH = 26;
   localparam int DEF_DATA_WIDTH = 128;

   localparam logic [DEF_DATA_WIDTH-1:0] ZERO_FILL = '0;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(
      input logic [15:0] s
   );
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ddr2_local_responder_rd_delay_pipe.sv
// ddr2_rd_delay_pipe: fixed-depth valid+data shift line
// with synchronous clear, used as the read latency pipe.
module ddr2_rd_delay_pipe #(
   parameter int DEPTH = 4,
   parameter int W     = 128
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0] vld;
   logic [W-1:0]     dat [DEPTH];

   // shift valid and data one stage per cycle
   always_ff @(posedge clk) begin
      if (clr) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++)
            dat[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         dat[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/ddr2_local_responder.sv
// ddr2_local_responder: behavioural DDR2 local-side slave.
// Define DDR2_RESP_STALL_EN for LFSR-driven ready gaps.
module ddr2_local_responder
   import ddr2_local_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int MEM_AW          = 4,
   parameter int ADDR_LSB        = 22,
   parameter int READ_LATENCY    = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int INIT_CYCLES     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] local_address,
   input  logic                  local_burstbegin,
   input  logic                  local_read_req,
   input  logic                  local_write_req,
   input  logic [DATA_WIDTH-1:0] local_wdata,
   output logic                  local_ready,
   output logic                  local_init_done,
   output logic [DATA_WIDTH-1:0] local_rdata,
   output logic                  local_rdata_valid,
   output logic                  proto_err
);

   localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
   localparam int ENTRIES = 1 << MEM_AW;

   logic [DATA_WIDTH-1:0] mem [ENTRIES];
   logic [ENTRIES-1:0]    written;
   logic [INIT_W-1:0]     init_cnt;
   logic                  init_done;
   logic [3:0]            outstanding;
   logic [15:0]           burst_cnt;
   logic                  stall;
   logic                  req;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  pipe_valid;
   logic [MEM_AW-1:0]     idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] pipe_in;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic                  unused_addr;

   assign idx         = local_address[ADDR_LSB +: MEM_AW];
   assign unused_addr = ^local_address;
   assign req         = local_read_req | local_write_req;

   assign local_ready = init_done && !stall &&
      (outstanding < 4'(MAX_OUTSTANDING));

   assign wr_acc = local_ready && local_write_req;
   assign rd_acc = local_ready && local_read_req &&
      !local_write_req;

   assign rd_data = written[idx] ? mem[idx] :
      DATA_WIDTH'(ZERO_FILL);
   assign pipe_in = rd_acc ? rd_data :
      DATA_WIDTH'(ZERO_FILL);

   assign local_init_done   = init_done;
   assign local_rdata       = pipe_data;
   assign local_rdata_valid = pipe_valid;

`ifdef DDR2_RESP_STALL_EN
   logic [15:0] lfsr;

   // pseudo-random ready gaps once init is complete
   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else if (init_done)
         lfsr <= lfsr_next(lfsr);
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // calibration emulation: count, then hold init_done
   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else if (!init_done) begin
         if (init_cnt == INIT_W'(INIT_CYCLES - 1))
            init_done <= 1'b1;
         else
            init_cnt <= init_cnt + 1'b1;
      end
   end

   // array data is intentionally left unreset
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[idx] <= local_wdata;
   end

   // written bits, outstanding reads, error and burst count
   always_ff @(posedge clk) begin
      if (rst) begin
         written     <= '0;
         outstanding <= '0;
         proto_err   <= 1'b0;
         burst_cnt   <= '0;
      end else begin
         if (wr_acc)
            written[idx] <= 1'b1;
         unique case ({rd_acc, pipe_valid})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if ((req && !init_done) ||
             (local_ready && local_read_req &&
              local_write_req))
            proto_err <= 1'b1;
         if ((rd_acc || wr_acc) && local_burstbegin)
            burst_cnt <= burst_cnt + 1'b1;
      end
   end

   ddr2_rd_delay_pipe #(
      .DEPTH (READ_LATENCY),
      .W     (DATA_WIDTH)
   ) u_pipe (
      .clk       (clk),
      .clr       (rst),
      .in_valid  (rd_acc),
      .in_data   (pipe_in),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

endmodule

// File: tb/tb_ddr2_local_responder.sv
// tb_ddr2_local_responder: table vectors, directed corner
// sequences and random traffic against a queue model.
module tb_ddr2_local_responder;

   localparam int AW   = 26;
   localparam int DW   = 128;
   localparam int L    = 4;
   localparam int MAXO = 8;
   localparam int INIT = 64;
   localparam logic [DW-1:0] XV =
      128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
   localparam logic [DW-1:0] YV =
      128'hC0FF_EE00_1111_2222_3333_4444_5555_6666;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] local_address = '0;
   logic          local_burstbegin = 1'b0;
   logic          local_read_req = 1'b0;
   logic          local_write_req = 1'b0;
   logic [DW-1:0] local_wdata = '0;
   logic          local_ready;
   logic          local_init_done;
   logic [DW-1:0] local_rdata;
   logic          local_rdata_valid;
   logic          proto_err;

   always #5 clk = ~clk;

   ddr2_local_responder dut (
      .clk               (clk),
      .rst               (rst),
      .local_address     (local_address),
      .local_burstbegin  (local_burstbegin),
      .local_read_req    (local_read_req),
      .local_write_req   (local_write_req),
      .local_wdata       (local_wdata),
      .local_ready       (local_ready),
      .local_init_done   (local_init_done),
      .local_rdata       (local_rdata),
      .local_rdata_valid (local_rdata_valid),
      .proto_err         (proto_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } beat_t;

   typedef struct {
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   beat_t         q[$];
   logic [DW-1:0] mem_m [16];
   bit            wr_m [16];
   int            cyc;
   int            k;
   bit            perr_m;
   logic [15:0]   burst_m;
   logic [15:0]   lfsr_m;
   int            checks;
   int            failures;
   int            beats;
   bit            tab_mode;
   logic [DW-1:0] tab_exp[$];
   vec_t          tab[35];

   task automatic chk(input string nm,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      foreach (wr_m[j]) wr_m[j] = 1'b0;
      k       = 0;
      perr_m  = 1'b0;
      burst_m = '0;
      lfsr_m  = 16'hACE1;
   endtask

   function automatic bit m_ready();
      bit s;
      s = 1'b0;
`ifdef DDR2_RESP_STALL_EN
      s = (lfsr_m[1:0] == 2'b00);
`endif
      return (k >= INIT) && (q.size() < MAXO) && !s;
   endfunction

   task automatic step(input bit r, input bit rd,
                       input bit wr, input bit bb,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] wd,
                       output bit acc);
      bit            rdy;
      bit            ev;
      int            i;
      logic [DW-1:0] d;
      rst              = r;
      local_read_req   = rd;
      local_write_req  = wr;
      local_burstbegin = bb;
      local_address    = a;
      local_wdata      = wd;
      @(negedge clk);
      rdy = m_ready();
      ev  = (q.size() > 0) && (q[0].due == cyc);
      chk("init_done", local_init_done, k >= INIT);
      chk("ready", local_ready, rdy);
      chk("rdata_valid", local_rdata_valid, ev);
      chk("proto_err", proto_err, perr_m);
      if (local_rdata_valid === 1'b1) beats++;
      if (ev) begin
         chk("rdata", local_rdata, q[0].data);
         if (tab_mode) begin
            if (tab_exp.size() == 0)
               chk("tab_extra_beat", local_rdata_valid, 0);
            else
               chk("tab_rdata", local_rdata,
                   tab_exp.pop_front());
         end
      end
      i   = int'(a[22 +: 4]);
      acc = rdy && (rd || wr) && !r;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (ev) void'(q.pop_front());
         if (acc && rd && !wr) begin
            d = wr_m[i] ? mem_m[i] : '0;
            q.push_back('{d, cyc + L});
         end
         if (acc && wr) begin
            mem_m[i] = wd;
            wr_m[i]  = 1'b1;
         end
         if ((rd || wr) && (k < INIT || (rdy && rd && wr)))
            perr_m = 1'b1;
         if (acc && bb) burst_m++;
         if (k >= INIT)
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^
               lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
         k++;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int j = 0; j < n; j++)
         step(0, 0, 0, 0, '0, '0, acc);
   endtask

   task automatic held(input bit rd, input bit wr,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] wd,
                       output bit acc);
      int g;
      g = 0;
      acc = 0;
      while (!acc && g < 60) begin
         step(0, rd, wr, 1, a, wd, acc);
         g++;
      end
      if (!acc) chk("hold_timeout", acc, 1);
   endtask

   initial begin
      bit acc;
      int n;
      int b0;
      checks   = 0;
      failures = 0;
      beats    = 0;
      cyc      = 0;
      tab_mode = 0;

      tab[0] = '{1, 0, 26'h1400000, '0, '0};
      tab[1] = '{0, 1, 26'h1400000, XV, '0};
      tab[2] = '{1, 0, 26'h1400000, '0, XV};
      for (int j = 0; j < 16; j++) begin
         tab[3+j]  = '{0, 1, AW'(j) << 22, DW'(j), '0};
         tab[19+j] = '{1, 0, AW'(j) << 22, '0, DW'(j)};
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      chk("rst_ready", local_ready, 0);
      chk("rst_init_done", local_init_done, 0);
      chk("rst_rdata", local_rdata, 0);
      chk("rst_rdata_valid", local_rdata_valid, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_outstanding", dut.outstanding, 0);
      @(posedge clk);
      #1;

      idle(63);
      chk("init_63", local_init_done, 0);
      idle(1);
      chk("init_64", local_init_done, 1);
      chk("ready_at_init", local_ready, 1);

      tab_mode = 1;
      for (int r = 0; r < 35; r++) begin
         held(tab[r].rd, tab[r].wr, tab[r].addr,
              tab[r].wdata, acc);
         if (acc && tab[r].rd)
            tab_exp.push_back(tab[r].exp);
      end
      idle(8);
      tab_mode = 0;
      chk("tab_drain", tab_exp.size(), 0);
      chk("no_err_yet", proto_err, 0);

      b0 = beats;
      n  = 0;
      for (int g = 0; g < 100 && n < 9; g++) begin
         step(0, 1, 0, 0, AW'($urandom), '0, acc);
         if (acc) n++;
      end
      idle(10);
      chk("b2b_accepts", n, 9);
      chk("b2b_beats", beats - b0, 9);

      b0 = beats;
      held(1, 1, 26'h2000000, YV, acc);
      idle(8);
      chk("both_no_beat", beats - b0, 0);
      chk("both_err", proto_err, 1);
      held(1, 0, 26'h2000000, '0, acc);
      idle(8);
      chk("both_wr_kept", beats - b0, 1);
      chk("err_sticky", proto_err, 1);
      chk("burst_cnt_a", dut.burst_cnt, burst_m);

      for (int j = 0; j < 3; j++)
         held(1, 0, AW'(j) << 22, '0, acc);
      step(1, 0, 0, 0, '0, '0, acc);
      chk("midrst_outst", dut.outstanding, 0);
      chk("midrst_ready", local_ready, 0);
      chk("midrst_err", proto_err, 0);
      b0 = beats;
      idle(5);
      step(0, 1, 0, 0, '0, '0, acc);
      chk("preinit_err", proto_err, 1);
      idle(INIT);
      chk("midrst_no_beats", beats - b0, 0);
      chk("reinit", local_init_done, 1);

      for (int j = 0; j < 600; j++) begin
         step(0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1,
              AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              acc);
      end
      idle(10);
      chk("burst_cnt_b", dut.burst_cnt, burst_m);
      chk("rand_drain", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
